// File: rtl/clk_reset_gen_if.sv
// Configuration and status bundle between the clock/reset generator and its controller.
// The controller drives the master side; the generator uses the slave side.
interface clk_reset_gen_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 4
);
  logic [NUM_CH*DIV_W-1:0] div_sel;
  logic [NUM_CH-1:0]       ch_enable;
  logic [NUM_CH-1:0]       ch_invert;
  logic [NUM_CH-1:0]       clk_out;
  logic                    sys_reset;
  logic                    ready;

  modport master (
    output div_sel,
    output ch_enable,
    output ch_invert,
    input  clk_out,
    input  sys_reset,
    input  ready
  );

  modport slave (
    input  div_sel,
    input  ch_enable,
    input  ch_invert,
    output clk_out,
    output sys_reset,
    output ready
  );
endinterface

// File: rtl/clk_reset_gen.sv
// Derives NUM_CH programmable divided clocks from the board clock and stretches the
// board reset into a system reset released RST_HOLD cycles after reset drops.
module clk_reset_gen #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DIV_W    = 4,
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned HOLD_W   = 3
) (
  input  logic           clock,
  input  logic           reset,
  clk_reset_gen_if.slave bus
);

  typedef enum logic [0:0] {StHold, StRun} state_e;

  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(RST_HOLD - 1);

  state_e                        state_q;
  logic [HOLD_W-1:0]             hold_cnt_q;
  logic                          first_q;
  logic                          sys_reset_q;
  logic                          ready_q;

  logic [NUM_CH-1:0][DIV_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0]  div_q, div_d;
  logic [NUM_CH-1:0][DIV_W-1:0]  eff_div;
  logic [NUM_CH-1:0]             phase_q, phase_d;
  logic [NUM_CH-1:0]             clk_q, clk_d;

  // Reset sequencer: HOLD counts out the stretch, RUN is terminal until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      first_q     <= 1'b0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          if (hold_cnt_q == HoldLast) begin
            state_q     <= StRun;
            first_q     <= 1'b1;
            sys_reset_q <= 1'b0;
            ready_q     <= 1'b1;
          end
        end
        StRun: begin
          first_q <= 1'b0;
        end
        default: state_q <= StHold;
      endcase
    end
  end

  // The divisor is only taken from div_sel on the first RUN cycle or at a toggle,
  // so a half-period is never cut short by a software update.
  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    phase_d = phase_q;
    clk_d   = clk_q;
    eff_div = div_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q != StRun) begin
        cnt_d[i]   = '0;
        div_d[i]   = '0;
        phase_d[i] = 1'b0;
        clk_d[i]   = 1'b0;
      end else begin
        if (first_q) begin
          eff_div[i] = bus.div_sel[i*DIV_W +: DIV_W];
          div_d[i]   = bus.div_sel[i*DIV_W +: DIV_W];
        end
        if (bus.ch_enable[i]) begin
          if (cnt_q[i] == eff_div[i]) begin
            cnt_d[i]   = '0;
            phase_d[i] = ~phase_q[i];
            div_d[i]   = bus.div_sel[i*DIV_W +: DIV_W];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
          clk_d[i] = phase_d[i] ^ bus.ch_invert[i];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      div_q   <= '0;
      phase_q <= '0;
      clk_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      clk_q   <= clk_d;
    end
  end

  assign bus.clk_out   = clk_q;
  assign bus.sys_reset = sys_reset_q;
  assign bus.ready     = ready_q;

endmodule

// File: doc/clk_reset_gen.md
Name: clk_reset_gen

Overview:
- Synthesisable clock-and-reset generator for the processor skeleton.
- Divides the single board clock into NUM_CH derived clocks, each with a runtime-programmable half-period, plus per-channel enable and invert. Typical channels: imem, dmem, processor, regfile.
- Stretches the incoming reset into a clean system reset released a fixed number of cycles after the board reset drops.
- Sits between the top-level clock/reset pins and all clocked sub-blocks.

Parameters:
- NUM_CH, 4: number of derived clock channels.
- DIV_W, 4: width of each channel's divisor field.
- RST_HOLD, 4: clock cycles sys_reset stays high after reset deasserts (min 1).
- HOLD_W, 3: width of the hold counter; must satisfy 2^HOLD_W > RST_HOLD.

Ports:
- clock, in, 1: board clock; all logic on rising edge.
- reset, in, 1: asynchronous, active-high reset.
- div_sel, in, NUM_CH*DIV_W: channel i divisor at bits [i*DIV_W +: DIV_W]. Half-period = div+1 clock cycles.
- ch_enable, in, NUM_CH: per-channel run enable.
- ch_invert, in, NUM_CH: per-channel output polarity invert.
- clk_out, out, NUM_CH: derived clocks, registered.
- sys_reset, out, 1: stretched system reset, registered, active-high.
- ready, out, 1: high once the sequencer is in RUN.

Behaviour:
- Reset values, asynchronous on reset=1:
  - State=HOLD, hold counter=0.
  - sys_reset=1, ready=0.
  - All clk_out=0, all phase bits=0, all channel counters=0.
  - All latched divisors=0.
- FSM states:
  - HOLD: hold counter increments each cycle. When the counter reaches RST_HOLD-1, go to RUN on the next edge. That edge sets sys_reset=0 and ready=1.
  - Result: sys_reset falls on the RST_HOLD-th rising edge after reset deasserts.
  - RUN: terminal state; left only by reset.
- Reset mid-operation: immediate return to reset values on any cycle. The full RST_HOLD stretch is reapplied. No partial clock pulse is held over.
- Channels are frozen (counter=0, phase=0, clk_out=0) while state is HOLD.
- Per-channel operation in RUN with ch_enable[i]=1:
  - The counter increments each cycle.
  - When counter == latched_div[i]: counter returns to 0, phase[i] toggles, and latched_div[i] reloads from div_sel.
  - Derived period = 2*(div+1) cycles, 50% duty. div=0 gives clock/2; div=2^DIV_W-1 gives clock/(2^(DIV_W+1)).
- Divisor change: sampled only at a toggle or on the first cycle of RUN, so there is never a glitch or short half-period. A change mid-half-period takes effect from the next half-period.
- First RUN cycle: latched_div loads from div_sel and the counter starts at 0. The first clk_out rising edge occurs (div+1) cycles after ready rises, assuming no invert.
- ch_enable[i]=0:
  - Counter and phase hold their values; clk_out holds its level.
  - Re-enabling resumes from the held count; no reset of the phase.
- clk_out[i] is the register of phase[i] XOR ch_invert[i]. It updates every cycle in RUN, so an invert change appears one cycle later and may shorten one half-period. Invert changes are software-controlled and done only while the channel is disabled.
- Simultaneous cases:
  - A toggle and div_sel change in the same cycle: the new value is latched on that cycle.
  - Enable dropping in a toggle cycle: the toggle does not occur; enable gates the whole update.
- Channels are fully independent; no phase alignment between channels is guaranteed except identical divisors enabled on the same cycle, which stay in lockstep.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset sequence: hold reset 3 cycles, release, RST_HOLD=4 -> sys_reset high for exactly 4 rising edges after release, then 0; ready rises on the same edge; clk_out all 0 throughout HOLD.
- Divide ratios: div_sel = {3,2,1,0} for ch3..ch0, all enabled -> ch0 period 2 cycles, ch1 4, ch2 6, ch3 8, 50% duty. Check 10 periods each.
- Divisor change: ch0 div=3 running, change to 0 mid-half-period -> current half-period completes at 4 cycles, then 1-cycle half-periods; no pulse shorter than 1 cycle.
- Enable/invert: ch1 div=1, disable after 3 cycles -> clk_out[1] frozen; set invert, wait, re-enable -> output is inverted phase and continues from the held count.
- Async reset mid-run: assert reset between clock edges while channels toggle -> sys_reset=1, ready=0 and clk_out=0 immediately, before the next edge; after release, the full 4-cycle stretch repeats.
- Max divisor: DIV_W=4, div=15 -> period 32 cycles; counter wrap is correct with no overflow glitch.
